// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: prescaled digit scan, frame-synchronous
// shadow update, leading-zero blanking and PWM dimming with registered pin outputs.
module seg7_scan_driver #(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned DIM_BITS    = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    display_on,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    update,
   input  logic                    blank_lz,
   input  logic [DIM_BITS-1:0]     brightness,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              cathode,
   output logic                    dp,
   output logic                    pending,
   output logic                    frame_tick
);

   localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
   localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   logic [PRE_W-1:0]        pre_q, pre_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [DIM_BITS-1:0]     pwm_q, pwm_d;
   logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
   logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
   logic                    pending_q, pending_d;
   logic                    frame_tick_q, frame_tick_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [6:0]              cathode_q, cathode_d;
   logic                    dp_q, dp_d;

   logic                    terminal, wrap, load, lit;
   logic [NUM_DIGITS-1:0]   blank;
   logic                    zero_run;
   logic [3:0]              cur_nib;
   logic                    cur_dp, cur_blank;

   function automatic logic [6:0] decode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      return seg;
   endfunction

   assign terminal = (pre_q == PRE_W'(REFRESH_DIV - 1));
   // Frame start is the edge where the last digit slot ends; the shadow load lands on it.
   assign wrap     = terminal && (idx_q == IDX_W'(NUM_DIGITS - 1));
   assign load     = wrap && (pending_q || update);
   assign lit      = (pwm_q <= brightness);

   always_comb begin
      pre_d        = terminal ? '0 : pre_q + PRE_W'(1);
      idx_d        = idx_q;
      if (terminal) idx_d = wrap ? '0 : idx_q + IDX_W'(1);
      pwm_d        = pwm_q + DIM_BITS'(1);
      frame_tick_d = wrap;
      pending_d    = pending_q;
      if (wrap) pending_d = 1'b0;
      else if (update) pending_d = 1'b1;
      shadow_d     = load ? digits : shadow_q;
      shadow_dp_d  = load ? dp_in : shadow_dp_q;
   end

   // A digit is blanked when it and every more-significant shadow nibble are zero.
   always_comb begin
      blank    = '0;
      zero_run = 1'b1;
      for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_run = zero_run && (shadow_q[4*i +: 4] == 4'h0);
         blank[i] = blank_lz && zero_run;
      end
   end

   always_comb begin
      cur_nib   = '0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_nib   = shadow_q[4*i +: 4];
            cur_dp    = shadow_dp_q[i];
            cur_blank = blank[i];
         end
      end
      an_d      = '1;
      cathode_d = 7'h7F;
      dp_d      = 1'b1;
      if (display_on && !cur_blank && lit) begin
         for (int unsigned i = 0; i < NUM_DIGITS; i++) an_d[i] = (idx_q != IDX_W'(i));
         cathode_d = decode(cur_nib);
         dp_d      = ~cur_dp;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q        <= '0;
         idx_q        <= '0;
         pwm_q        <= '0;
         shadow_q     <= '0;
         shadow_dp_q  <= '0;
         pending_q    <= 1'b0;
         frame_tick_q <= 1'b0;
         an_q         <= '1;
         cathode_q    <= 7'h7F;
         dp_q         <= 1'b1;
      end else begin
         pre_q        <= pre_d;
         idx_q        <= idx_d;
         pwm_q        <= pwm_d;
         shadow_q     <= shadow_d;
         shadow_dp_q  <= shadow_dp_d;
         pending_q    <= pending_d;
         frame_tick_q <= frame_tick_d;
         an_q         <= an_d;
         cathode_q    <= cathode_d;
         dp_q         <= dp_d;
      end
   end

   assign an         = an_q;
   assign cathode    = cathode_q;
   assign dp         = dp_q;
   assign pending    = pending_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4-digit instance for scan/update/blanking/PWM,
// 1-digit instance for the full decode table.
module tb_seg7_scan_driver;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        display_on = 1'b1;
   logic        blank_lz = 1'b0;
   logic [1:0]  brightness = 2'b11;

   logic [15:0] digits = 16'h0000;
   logic [3:0]  dp_in = 4'b0000;
   logic        update = 1'b0;
   logic [3:0]  an;
   logic [6:0]  cathode;
   logic        dp, pending, frame_tick;

   logic [3:0]  d2_digits = 4'h0;
   logic        d2_dp = 1'b0;
   logic        d2_update = 1'b0;
   logic        an_b;
   logic [6:0]  cathode_b;
   logic        dp_b, pending_b, frame_tick_b;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .DIM_BITS(2)) dut (
      .clk(clk), .rst_n(rst_n), .display_on(display_on), .digits(digits),
      .dp_in(dp_in), .update(update), .blank_lz(blank_lz), .brightness(brightness),
      .an(an), .cathode(cathode), .dp(dp), .pending(pending), .frame_tick(frame_tick)
   );

   seg7_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(4), .DIM_BITS(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .display_on(display_on), .digits(d2_digits),
      .dp_in(d2_dp), .update(d2_update), .blank_lz(blank_lz), .brightness(brightness),
      .an(an_b), .cathode(cathode_b), .dp(dp_b), .pending(pending_b),
      .frame_tick(frame_tick_b)
   );

   function automatic logic [6:0] seg_ref(input logic [3:0] c);
      case (c)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   // Always advances at least one negedge, so it never returns on the tick it started on.
   task automatic wait_tick(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (frame_tick !== 1'b1 && n < 64);
      if (frame_tick !== 1'b1) begin
         vectors++; miscompares++;
         $display("FAIL tick_timeout got no frame_tick exp frame_tick within 64 cycles");
      end
   endtask

   task automatic pulse_update();
      @(negedge clk); update = 1'b1;
      @(negedge clk); update = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      #12;
      vectors++;
      if (an !== 4'b1111 || cathode !== 7'h7F || dp !== 1'b1 || pending !== 1'b0 || frame_tick !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_init got an=%b cath=%h dp=%b pend=%b tick=%b exp 1111/7f/1/0/0", an, cathode, dp, pending, frame_tick);
      end
      @(negedge clk); rst_n = 1'b1;
      digits = 16'h1234; update = 1'b1;
      @(negedge clk); update = 1'b0;
      vectors++;
      if (pending !== 1'b1) begin
         miscompares++; $display("FAIL reset_pend_set got %b exp 1", pending);
      end
      repeat (5) @(negedge clk);
      vectors++;
      if (an !== 4'b1101 || cathode !== 7'h40) begin
         miscompares++; $display("FAIL reset_prescan got an=%b cath=%h exp 1101/40", an, cathode);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if (an !== 4'b1111 || cathode !== 7'h7F || dp !== 1'b1 || pending !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_async got an=%b cath=%h dp=%b pend=%b exp 1111/7f/1/0", an, cathode, dp, pending);
      end
      @(negedge clk); rst_n = 1'b1;
      wait_tick(n);
      vectors++;
      if (n != 16) begin
         miscompares++; $display("FAIL reset_first_tick got %0d cycles exp 16", n);
      end
      @(negedge clk);
      vectors++;
      if (an !== 4'b1110 || cathode !== 7'h40) begin
         miscompares++; $display("FAIL reset_update_lost got an=%b cath=%h exp 1110/40", an, cathode);
      end
   endtask

   task automatic test_scan();
      int n;
      logic [6:0] tab [4];
      logic [3:0] an_e;
      int idx;
      tab = '{7'h19, 7'h30, 7'h24, 7'h79};
      digits = 16'h1234; dp_in = 4'b0101;
      pulse_update();
      wait_tick(n);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         idx = (k - 1) / 4;
         an_e = 4'b1111; an_e[idx] = 1'b0;
         vectors++;
         if (an !== an_e || cathode !== tab[idx] || dp !== ~dp_in[idx]) begin
            miscompares++;
            $display("FAIL scan k=%0d got an=%b cath=%h dp=%b exp %b/%h/%b", k, an, cathode, dp, an_e, tab[idx], ~dp_in[idx]);
         end
      end
   endtask

   task automatic test_tear_free();
      int n;
      wait_tick(n);
      repeat (5) @(negedge clk);
      digits = 16'hABCD; update = 1'b1;
      @(negedge clk); update = 1'b0;
      vectors++;
      if (pending !== 1'b1 || an !== 4'b1101 || cathode !== 7'h30) begin
         miscompares++; $display("FAIL tear_midframe got pend=%b an=%b cath=%h exp 1/1101/30", pending, an, cathode);
      end
      repeat (9) @(negedge clk);
      vectors++;
      if (pending !== 1'b1 || frame_tick !== 1'b0 || an !== 4'b0111 || cathode !== 7'h79) begin
         miscompares++;
         $display("FAIL tear_endframe got pend=%b tick=%b an=%b cath=%h exp 1/0/0111/79", pending, frame_tick, an, cathode);
      end
      @(negedge clk);
      vectors++;
      if (frame_tick !== 1'b1 || pending !== 1'b0 || cathode !== 7'h79) begin
         miscompares++; $display("FAIL tear_tick got tick=%b pend=%b cath=%h exp 1/0/79", frame_tick, pending, cathode);
      end
      @(negedge clk);
      vectors++;
      if (an !== 4'b1110 || cathode !== 7'h21) begin
         miscompares++; $display("FAIL tear_new0 got an=%b cath=%h exp 1110/21", an, cathode);
      end
      repeat (4) @(negedge clk);
      vectors++;
      if (an !== 4'b1101 || cathode !== 7'h46) begin
         miscompares++; $display("FAIL tear_new1 got an=%b cath=%h exp 1101/46", an, cathode);
      end
   endtask

   task automatic test_blanking();
      int n;
      logic [3:0] an_t1 [4];
      logic [6:0] ca_t1 [4];
      logic [3:0] an_t2 [4];
      logic [6:0] ca_t2 [4];
      int idx;
      an_t1 = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
      ca_t1 = '{7'h40, 7'h12, 7'h7F, 7'h7F};
      an_t2 = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
      ca_t2 = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
      blank_lz = 1'b1; dp_in = 4'b0000; digits = 16'h0050;
      pulse_update();
      wait_tick(n);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         idx = (k - 1) / 4;
         vectors++;
         if (an !== an_t1[idx] || cathode !== ca_t1[idx] || dp !== 1'b1) begin
            miscompares++;
            $display("FAIL blank_0050 k=%0d got an=%b cath=%h dp=%b exp %b/%h/1", k, an, cathode, dp, an_t1[idx], ca_t1[idx]);
         end
      end
      digits = 16'h0000;
      pulse_update();
      wait_tick(n);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         idx = (k - 1) / 4;
         vectors++;
         if (an !== an_t2[idx] || cathode !== ca_t2[idx]) begin
            miscompares++;
            $display("FAIL blank_0000 k=%0d got an=%b cath=%h exp %b/%h", k, an, cathode, an_t2[idx], ca_t2[idx]);
         end
      end
      blank_lz = 1'b0;
   endtask

   task automatic test_brightness();
      int n, idx, pwm, active;
      logic [3:0] an_e;
      logic [6:0] ca_e;
      logic [6:0] tab [4];
      logic [1:0] levels [2];
      int want [2];
      tab = '{7'h19, 7'h30, 7'h24, 7'h79};
      levels = '{2'b00, 2'b01};
      want = '{1, 2};
      digits = 16'h1234;
      pulse_update();
      for (int l = 0; l < 2; l++) begin
         brightness = levels[l];
         wait_tick(n);
         active = 0;
         for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            idx = (k - 1) / 4;
            pwm = (k - 1) % 4;
            an_e = 4'b1111; ca_e = 7'h7F;
            if (pwm <= int'(levels[l])) begin
               an_e[idx] = 1'b0; ca_e = tab[idx];
            end
            if (idx == 0 && an !== 4'b1111) active++;
            vectors++;
            if (an !== an_e || cathode !== ca_e) begin
               miscompares++;
               $display("FAIL pwm_b%0d k=%0d got an=%b cath=%h exp %b/%h", l, k, an, cathode, an_e, ca_e);
            end
         end
         vectors++;
         if (active != want[l]) begin
            miscompares++; $display("FAIL pwm_duty_b%0d got %0d lit cycles exp %0d", l, active, want[l]);
         end
      end
      brightness = 2'b11;
      repeat (2) @(negedge clk);
      vectors++;
      if (an === 4'b1111) begin
         miscompares++; $display("FAIL pwm_full got an=%b exp one low bit", an);
      end
      display_on = 1'b0;
      @(negedge clk);
      vectors++;
      if (an !== 4'b1111 || cathode !== 7'h7F || dp !== 1'b1) begin
         miscompares++; $display("FAIL display_off got an=%b cath=%h dp=%b exp 1111/7f/1", an, cathode, dp);
      end
      display_on = 1'b1;
   endtask

   task automatic test_decode();
      int n;
      logic [3:0] c;
      for (int i = 0; i < 16; i++) begin
         c = 4'(i);
         d2_digits = c; d2_dp = c[0];
         @(negedge clk); d2_update = 1'b1;
         @(negedge clk); d2_update = 1'b0;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (frame_tick_b !== 1'b1 && n < 32);
         @(negedge clk);
         vectors++;
         if (n >= 32 || an_b !== 1'b0 || cathode_b !== seg_ref(c) || dp_b !== ~c[0]) begin
            miscompares++;
            $display("FAIL decode code=%h got an=%b cath=%h dp=%b waited=%0d exp 0/%h/%b", c, an_b, cathode_b, dp_b, n, seg_ref(c), ~c[0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_tear_free();
      test_blanking();
      test_brightness();
      test_decode();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed seven-segment display driver for the lab board. It takes NUM_DIGITS hex nibbles plus decimal points and scans them onto a common-cathode-bus / per-digit-anode display. Compared with the combinational single-digit decoder, it adds:
- a refresh prescaler and digit scanner,
- frame-synchronous tear-free update through a shadow register,
- leading-zero blanking,
- PWM brightness control.

It sits between the board's register/switch logic and the an/cathode/dp pins.

## Interface
- NUM_DIGITS, 4, digits scanned (legal 1..8)
- REFRESH_DIV, 100000, clk cycles per digit slot (legal ≥ 2)
- DIM_BITS, 4, width of brightness and PWM counter (legal 1..8)

- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- display_on  in  1  0 forces all anodes off
- digits  in  4*NUM_DIGITS  hex codes; nibble i = digit i, digit 0 rightmost
- dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
- update  in  1  one-cycle request to copy digits/dp_in into shadow at next frame start
- blank_lz  in  1  1 = leading-zero blanking enabled
- brightness  in  DIM_BITS  duty = (brightness+1)/2^DIM_BITS
- an  out  NUM_DIGITS  active-low anode enables, one-hot-low or all 1
- cathode  out  7  active-low segments, cathode[0]=a … cathode[6]=g
- dp  out  1  active-low decimal point
- pending  out  1  update accepted, not yet applied
- frame_tick  out  1  one-cycle pulse at each frame start

## Operation
- Prescaler `pre` counts 0..REFRESH_DIV-1 and wraps. At terminal count, digit index `idx` advances: NUM_DIGITS-1 wraps to 0.
- Frame start is the cycle in which `idx` wraps to 0. In that cycle:
  - frame_tick is asserted;
  - if pending=1, the shadow digits/dp are loaded from the inputs sampled in that cycle, and pending clears.
- update=1 sets pending. update coincident with a frame start loads immediately in that cycle, and pending stays 0.
- PWM counter `pwm` (DIM_BITS wide) increments every clk and wraps freely. The digit is lit when pwm ≤ brightness. Brightness all-ones = always lit.
- Decode, as active-low hex, gfedcba:
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
  - 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
- Leading-zero blanking: digit i>0 is blanked when blank_lz=1 and shadow nibbles NUM_DIGITS-1 down to i are all 0. Digit 0 is never blanked.
- Active digit idx is driven when display_on=1, it is not blanked, and the PWM is lit:
  - an bit idx = 0, all other an bits = 1;
  - cathode = decode(shadow[idx]);
  - dp = ~shadow_dp[idx].
- Otherwise: an all 1, cathode 7'h7F, dp 1.
- display_on, blank_lz and brightness act live; they are not shadowed.

## Timing
- Reset (async assert, sync-to-clk deassert effect):
  - pre=0, idx=0, pwm=0, shadow=0, shadow_dp=0, pending=0, frame_tick=0;
  - an all 1, cathode 7'h7F, dp 1.
- an, cathode and dp are registered. They reflect idx/pwm/shadow/display_on with one clk of latency.
- Digit slot length is exactly REFRESH_DIV cycles. A frame is NUM_DIGITS*REFRESH_DIV cycles.
- First frame_tick after reset occurs NUM_DIGITS*REFRESH_DIV cycles after the first active edge.
- NUM_DIGITS=1: idx is constant 0, and frame_tick pulses every REFRESH_DIV cycles.
- Repeated update while pending=1: no additional effect. The load takes the inputs present at the frame start, not those present at update.
- Reset mid-frame clears pending; any queued update is lost.
- Shadow contents change only at frame start, so a displayed value never changes mid-frame.

## Test plan
Benches use NUM_DIGITS=4, REFRESH_DIV=4, DIM_BITS=2 unless stated.

- Reset with rst_n=0 mid-scan → an=4'b1111, cathode=7'h7F, dp=1, pending=0 asynchronously. After release, the first frame_tick comes 16 cycles later.
- Scan order:
  - stimulus: digits=16'h1234, update pulsed, brightness=2'b11, display_on=1;
  - after the load frame: an goes 1110, 1101, 1011, 0111 for 4 cycles each;
  - cathode per slot: 30 (3 on 1110 is wrong); required is digit0=4 → 19, digit1=3 → 30, digit2=2 → 24, digit3=1 → 79.
- Tear-free update: change digits to 16'hABCD and pulse update mid-frame → pending=1, the old values finish the frame, new values appear at the cycle after frame_tick, and pending clears.
- Leading-zero blanking: digits=16'h0050, blank_lz=1 → digits 3 and 2 show an all 1, digit 1 shows 12, digit 0 shows 40. digits=16'h0000 → only digit 0 lit, showing 40.
- Brightness: brightness=2'b00 → an active only 1 cycle in every 4 within a slot. 2'b01 → 2 of 4 cycles. display_on=0 → an=1111 within one cycle.
- Decode sweep: NUM_DIGITS=1, codes 0..F with dp_in toggled → cathode matches the table for all 16 codes, and dp = ~dp_in.
